// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared encodings for the programmable up/down counter:
//               count direction and terminal-count behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // dir encoding
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;

  // mode encoding
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/prog_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : prog_updown_counter
// Description : Programmable-modulus up/down counter with synchronous clear,
//               load, wrap or one-shot terminal behaviour, terminal-count flag
//               and a carry-out for cascading instances.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous reset, active-high (d=RESET_VAL, done=0)
//   clr   in   1      synchronous clear to 0 (highest synchronous priority)
//   load  in   1      synchronous load of b (beats counting, ignores en)
//   en    in   1      count enable
//   dir   in   1      0 = up, 1 = down
//   mode  in   1      0 = wrap, 1 = one-shot
//   b     in   WIDTH  load value
//   l     in   WIDTH  terminal limit (modulus l+1)
//   d     out  WIDTH  registered count value
//   tc    out  1      terminal count, combinational from d, dir, l
//   co    out  1      carry-out, tc & en & ~done
//   done  out  1      registered one-shot complete flag
// ============================================================================
module prog_updown_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] l,
  output logic [WIDTH-1:0] d,
  output logic             tc,
  output logic             co,
  output logic             done
);

  localparam logic [WIDTH-1:0] D_RESET = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] d_next;
  logic             done_next;

  // Terminal count: up stops at l, down stops at 0.
  assign tc = (dir == DIR_UP) ? (d == l) : (d == '0);

  // A finished one-shot never propagates a carry, even if en is high.
  assign co = tc & en & ~done;

  always_comb begin
    d_next    = d;
    done_next = done;
    if (clr) begin
      d_next    = '0;
      done_next = 1'b0;
    end else if (load) begin
      d_next    = b;
      done_next = 1'b0;
    end else if (en && !done) begin
      if (tc) begin
        if (mode == MODE_ONESHOT) begin
          done_next = 1'b1;
        end else if (dir == DIR_UP) begin
          d_next = '0;
        end else begin
          d_next = l;
        end
      end else if (dir == DIR_UP) begin
        // Modular increment: a value loaded above l runs through the top,
        // wraps to 0 and then climbs to l.
        d_next = d + WIDTH'(1);
      end else begin
        d_next = d - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d    <= D_RESET;
      done <= 1'b0;
    end else begin
      d    <= d_next;
      done <= done_next;
    end
  end

endmodule : prog_updown_counter
`default_nettype wire

// File: tb/tb_prog_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_updown_counter
// Description : Directed self-checking bench for prog_updown_counter:
//               wrap, one-shot, async reset, control priority, limit edges
//               and a two-stage cascade.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- main instance (RESET_VAL = 0) ----------------
  logic       rst, clr, load, en, dir, mode;
  logic [3:0] b, l, d;
  logic       tc, co, done;

  prog_updown_counter #(.WIDTH(4), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .dir(dir),
    .mode(mode), .b(b), .l(l), .d(d), .tc(tc), .co(co), .done(done)
  );

  // ---------------- reset-value instance (RESET_VAL = 2) ----------------
  logic       r_rst, r_clr, r_load, r_en, r_dir, r_mode;
  logic [3:0] r_b, r_l, r_d;
  logic       r_tc, r_co, r_done;

  prog_updown_counter #(.WIDTH(4), .RESET_VAL(2)) dut_r (
    .clk(clk), .rst(r_rst), .clr(r_clr), .load(r_load), .en(r_en), .dir(r_dir),
    .mode(r_mode), .b(r_b), .l(r_l), .d(r_d), .tc(r_tc), .co(r_co), .done(r_done)
  );

  // ---------------- cascade pair ----------------
  logic       c_rst, c_en;
  logic [3:0] lo_d, hi_d;
  logic       lo_tc, lo_co, lo_done, hi_tc, hi_co, hi_done;

  prog_updown_counter #(.WIDTH(4), .RESET_VAL(0)) dut_lo (
    .clk(clk), .rst(c_rst), .clr(1'b0), .load(1'b0), .en(c_en), .dir(1'b0),
    .mode(1'b0), .b(4'd0), .l(4'd15), .d(lo_d), .tc(lo_tc), .co(lo_co), .done(lo_done)
  );

  prog_updown_counter #(.WIDTH(4), .RESET_VAL(0)) dut_hi (
    .clk(clk), .rst(c_rst), .clr(1'b0), .load(1'b0), .en(lo_co), .dir(1'b0),
    .mode(1'b0), .b(4'd0), .l(4'd15), .d(hi_d), .tc(hi_tc), .co(hi_co), .done(hi_done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tcs;
    int v;
    rst = 1; clr = 0; load = 0; en = 0; dir = 0; mode = 0; b = 0; l = 0;
    r_rst = 1; r_clr = 0; r_load = 0; r_en = 0; r_dir = 0; r_mode = 0; r_b = 0; r_l = 0;
    c_rst = 1; c_en = 0;
    #2;
    chk("reset_d", int'(d), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_r_d", int'(r_d), 2);
    tick();
    rst = 0; r_rst = 0; c_rst = 0;

    // ---- 1. up wrap, l=13, load 10 ----
    l = 13; dir = 0; mode = 0; load = 1; b = 10;
    tick();
    chk("t1_load_d", int'(d), 10);
    load = 0; en = 1;
    #1 chk("t1_tc_at10", int'(tc), 0);
    tick(); chk("t1_d11", int'(d), 11);
    tick(); chk("t1_d12", int'(d), 12);
    tick(); chk("t1_d13", int'(d), 13);
    chk("t1_tc13", int'(tc), 1);
    chk("t1_co13", int'(co), 1);
    tick(); chk("t1_wrap0", int'(d), 0);
    chk("t1_tc0", int'(tc), 0);
    tick(); chk("t1_d1", int'(d), 1);
    tcs = 0;
    for (int i = 0; i < 14; i++) begin
      tcs += int'(tc);
      tick();
    end
    chk("t1_tc_per_14", tcs, 1);
    chk("t1_period_d", int'(d), 1);

    // ---- 2. down one-shot from 5 ----
    en = 0; mode = 1; dir = 1; load = 1; b = 5;
    tick(); chk("t2_load5", int'(d), 5);
    load = 0; en = 1;
    for (int k = 4; k >= 0; k--) begin
      tick(); chk("t2_down", int'(d), k);
    end
    chk("t2_tc0", int'(tc), 1);
    chk("t2_co0", int'(co), 1);
    chk("t2_done_pre", int'(done), 0);
    tick();
    chk("t2_done", int'(done), 1);
    chk("t2_hold0", int'(d), 0);
    chk("t2_co_done", int'(co), 0);
    mode = 0;  // mode change alone must not restart
    tick();
    chk("t2_hold_done", int'(done), 1);
    chk("t2_hold_d", int'(d), 0);
    mode = 1; load = 1; b = 3;
    tick();
    chk("t2_reload_d", int'(d), 3);
    chk("t2_reload_done", int'(done), 0);
    load = 0;
    tick(); chk("t2_resume", int'(d), 2);

    // ---- 4. simultaneous controls ----
    mode = 0; dir = 0; l = 13; clr = 1; load = 1; b = 9; en = 1;
    tick(); chk("t4_clr_wins", int'(d), 0);
    clr = 0;
    tick(); chk("t4_load_no_inc", int'(d), 9);
    load = 0; en = 0;
    tick(); chk("t4_en0_hold", int'(d), 9);

    // ---- 5. edge limits ----
    l = 0; en = 1; clr = 1;
    tick(); chk("t5_clr", int'(d), 0);
    clr = 0;
    tick(); chk("t5_l0_d", int'(d), 0);
    chk("t5_l0_tc", int'(tc), 1);
    tick(); chk("t5_l0_d2", int'(d), 0);
    en = 0; dir = 1;
    #1 chk("t5_down_tc0", int'(tc), 1);
    dir = 0; l = 3; load = 1; b = 15;
    tick(); chk("t5_load15", int'(d), 15);
    chk("t5_tc15", int'(tc), 0);
    load = 0; en = 1;
    tick(); chk("t5_wrap0", int'(d), 0);
    tick(); chk("t5_d1", int'(d), 1);
    tick(); chk("t5_d2", int'(d), 2);
    tick(); chk("t5_d3", int'(d), 3);
    chk("t5_tc3", int'(tc), 1);
    tick(); chk("t5_back0", int'(d), 0);
    en = 0;

    // ---- 3. async reset mid-count on RESET_VAL=2 instance ----
    r_l = 15; r_dir = 0; r_mode = 0; r_load = 1; r_b = 5;
    tick(); chk("t3_load5", int'(r_d), 5);
    r_load = 0; r_en = 1;
    tick(); chk("t3_d6", int'(r_d), 6);
    tick(); chk("t3_d7", int'(r_d), 7);
    #2 r_rst = 1;
    #1 chk("t3_async_d", int'(r_d), 2);
    chk("t3_async_done", int'(r_done), 0);
    tick();
    chk("t3_held", int'(r_d), 2);
    r_rst = 0;
    tick(); chk("t3_resume3", int'(r_d), 3);
    tick(); chk("t3_resume4", int'(r_d), 4);
    r_en = 0;

    // ---- 6. cascade ----
    c_en = 1;
    for (int i = 0; i <= 256; i++) begin
      v = i % 256;
      chk($sformatf("t6_val_%0d", i), int'({hi_d, lo_d}), v);
      chk($sformatf("t6_hico_%0d", i), int'(hi_co), (v == 255) ? 1 : 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_prog_updown_counter
`default_nettype wire
